dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data memory with a test-completion mailbox.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses.
module dmem_responder #(
   parameter int DEPTH        = 64,
   parameter int WAIT_CYCLES  = 1,
   parameter int MAILBOX_ADDR = 100,
   parameter int PASS_VALUE   = 25
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReq,
   input  logic        MemWrite,
   input  logic [31:0] DataAddr,
   input  logic [31:0] WriteData,
   input  logic [1:0]  Size,
   output logic [31:0] ReadData,
   output logic        MemReady,
   output logic        Busy,
   output logic        Done,
   output logic        Pass,
   output logic        MisalignErr
);

   localparam int          IdxW     = $clog2(DEPTH);
   localparam logic [2:0]  WaitLoad = 3'(WAIT_CYCLES);
   localparam logic [31:0] MboxAddr = 32'(MAILBOX_ADDR);
   localparam logic [31:0] PassWord = 32'(PASS_VALUE);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t state;
   state_t nextState;

   logic [2:0]  waitCnt;
   logic        writeQ;
   logic [31:0] addrQ;
   logic [31:0] dataQ;
   logic [1:0]  sizeQ;

   logic [31:0] mem [DEPTH];

   logic            effWrite;
   logic [31:0]     effAddr;
   logic [31:0]     effData;
   logic [1:0]      effSize;
   logic            isByte;
   logic            isHalf;
   logic            isWord;
   logic            misalign;
   logic [IdxW-1:0] effIdx;
   logic [3:0]      laneMask;
   logic [31:0]     laneData;
   logic [31:0]     merged;
   logic            accept;
   logic            enterResp;
   logic            commit;
   logic            mboxHit;

   assign accept    = (state == IDLE) && MemReq;
   assign enterResp = (nextState == RESP) && (state != RESP);
   assign commit    = (state == RESP);
   assign MemReady  = (state == RESP);
   assign Busy      = (state != IDLE);

   // Live inputs while idle (zero-wait path), latched copy afterwards
   always_comb begin
      effWrite = writeQ;
      effAddr  = addrQ;
      effData  = dataQ;
      effSize  = sizeQ;
      if (state == IDLE) begin
         effWrite = MemWrite;
         effAddr  = DataAddr;
         effData  = WriteData;
         effSize  = Size;
      end
   end

   // Decode size into byte lanes and replicate store data across them
   always_comb begin
      isByte   = (effSize == 2'b00);
      isHalf   = (effSize == 2'b01);
      isWord   = effSize[1];
      effIdx   = effAddr[IdxW+1:2];
      laneMask = 4'b1111;
      laneData = effData;
      unique case (1'b1)
         isByte: begin
            laneMask = 4'b0001 << effAddr[1:0];
            laneData = {4{effData[7:0]}};
         end
         isHalf: begin
            laneMask = effAddr[1] ? 4'b1100 : 4'b0011;
            laneData = {2{effData[15:0]}};
         end
         default: begin
            laneMask = 4'b1111;
            laneData = effData;
         end
      endcase
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = (isHalf && effAddr[0]) ||
                     (isWord && (effAddr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign mboxHit = effWrite && isWord && !misalign &&
                    (effAddr == MboxAddr);

   // Merge the selected lanes into the currently stored word
   always_comb begin
      merged = mem[effIdx];
      for (int b = 0; b < 4; b++) begin
         if (laneMask[b]) begin
            merged[8*b +: 8] = laneData[8*b +: 8];
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (MemReq) begin
               nextState = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (waitCnt == 3'd0) begin
               nextState = RESP;
            end
         end
         RESP: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Wait-state counter, loaded when a request is accepted
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         waitCnt <= 3'd0;
      end else if (accept) begin
         waitCnt <= WaitLoad;
      end else if ((state == WAIT) && (waitCnt != 3'd0)) begin
         waitCnt <= waitCnt - 3'd1;
      end
   end

   // Capture the request at the accepting edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         writeQ <= 1'b0;
         addrQ  <= '0;
         dataQ  <= '0;
         sizeQ  <= 2'b00;
      end else if (accept) begin
         writeQ <= MemWrite;
         addrQ  <= DataAddr;
         dataQ  <= WriteData;
         sizeQ  <= Size;
      end
   end

   // Load data becomes valid on entry to RESP and holds until the next load
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ReadData <= '0;
      end else if (enterResp && !effWrite) begin
         ReadData <= misalign ? '0 : mem[effIdx];
      end
   end

   // Stores land in the array on the edge leaving RESP
   always_ff @(posedge clk) begin
      if (commit && effWrite && !misalign) begin
         mem[effIdx] <= merged;
      end
   end

   // First word store to the mailbox latches the test verdict
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Done <= 1'b0;
         Pass <= 1'b0;
      end else if (commit && mboxHit && !Done) begin
         Done <= 1'b1;
         Pass <= (effData == PassWord);
      end
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   // Sticky misalignment flag, raised when the bad access completes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         MisalignErr <= 1'b0;
      end else if (commit && misalign) begin
         MisalignErr <= 1'b1;
      end
   end
`else
   assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with a byte-level reference model.
// Covers timing, lane writes, mailbox, reset abort, wrap and alignment.
module tb_dmem_responder;

   localparam int DEPTH = 64;
   localparam int WAITC = 1;
   localparam int MBOX  = 100;
   localparam int PASSV = 25;
   localparam int TOTAL = DEPTH * 4;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam bit MCHK = 1'b1;
`else
   localparam bit MCHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemReq = 1'b0;
   logic        MemWrite = 1'b0;
   logic [31:0] DataAddr = '0;
   logic [31:0] WriteData = '0;
   logic [1:0]  Size = 2'b00;
   logic [31:0] ReadData;
   logic        MemReady;
   logic        Busy;
   logic        Done;
   logic        Pass;
   logic        MisalignErr;

   int errs = 0;
   int checks = 0;

   dmem_responder #(
      .DEPTH(DEPTH),
      .WAIT_CYCLES(WAITC),
      .MAILBOX_ADDR(MBOX),
      .PASS_VALUE(PASSV)
   ) dut (
      .clk(clk),
      .reset(reset),
      .MemReq(MemReq),
      .MemWrite(MemWrite),
      .DataAddr(DataAddr),
      .WriteData(WriteData),
      .Size(Size),
      .ReadData(ReadData),
      .MemReady(MemReady),
      .Busy(Busy),
      .Done(Done),
      .Pass(Pass),
      .MisalignErr(MisalignErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed memory and request timeline
   logic [7:0]  mb [TOTAL];
   bit          mBusy = 0;
   bit          mReady = 0;
   int          mLeft = 0;
   bit          mDone = 0;
   bit          mPass = 0;
   bit          mMis = 0;
   logic [31:0] mRead = '0;
   bit          qW;
   logic [31:0] qA;
   logic [31:0] qD;
   logic [1:0]  qS;

   function automatic int nbytes(input logic [1:0] s);
      if (s == 2'b00) return 1;
      if (s == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit misal(input logic [31:0] a, input logic [1:0] s);
      return MCHK && ((int'(a[1:0]) % nbytes(s)) != 0);
   endfunction

   function automatic int wrapBase(input logic [31:0] a);
      return int'(a[15:0]) % TOTAL;
   endfunction

   initial begin
      for (int i = 0; i < TOTAL; i++) mb[i] = 8'h00;
   end

   always @(posedge clk) begin
      int n;
      int base;
      if (reset) begin
         mBusy = 0; mReady = 0; mLeft = 0;
         mDone = 0; mPass = 0; mMis = 0; mRead = '0;
      end else if (mReady) begin
         n = nbytes(qS);
         if (misal(qA, qS)) begin
            mMis = 1;
         end else if (qW) begin
            base = wrapBase(qA);
            base = base - (base % n);
            for (int i = 0; i < n; i++)
               mb[(base + i) % TOTAL] = qD[8*i +: 8];
            if (n == 4 && qA == 32'(MBOX) && !mDone) begin
               mDone = 1;
               mPass = (qD == 32'(PASSV));
            end
         end
         mReady = 0;
         mBusy = 0;
      end else if (mBusy) begin
         mLeft--;
         if (mLeft == 0) begin
            mReady = 1;
            if (!qW) begin
               base = wrapBase(qA);
               base = base - (base % 4);
               mRead = misal(qA, qS) ? 32'h0 :
                       {mb[base+3], mb[base+2], mb[base+1], mb[base]};
            end
         end
      end else if (MemReq) begin
         qW = MemWrite; qA = DataAddr; qD = WriteData; qS = Size;
         mBusy = 1;
         mLeft = 1 + WAITC;
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (reset) begin
         chk("rst_ready", MemReady, 0);
         chk("rst_busy", Busy, 0);
         chk("rst_done", Done, 0);
         chk("rst_pass", Pass, 0);
         chk("rst_mis", MisalignErr, 0);
         chk("rst_rdata", ReadData, 0);
      end else begin
         chk("ready", MemReady, mReady);
         chk("busy", Busy, mBusy);
         chk("done", Done, mDone);
         chk("pass", Pass, mPass);
         chk("mis", MisalignErr, mMis);
         chk("rdata", ReadData, mRead);
      end
   end

   // One request; junk is held on the bus while busy and must be ignored
   task automatic issue(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] s,
                        output logic [31:0] rd);
      int lat;
      bit seen;
      MemReq = 1; MemWrite = w; DataAddr = a; WriteData = d; Size = s;
      @(posedge clk); #1;
      MemWrite = 1; DataAddr = 32'h3C;
      WriteData = 32'hDEADDEAD; Size = 2'b10;
      lat = 0; seen = 0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(negedge clk);
         if (MemReady) begin
            seen = 1;
            lat = i;
         end
      end
      MemReq = 0;
      chk("latency", lat, 3);
      rd = ReadData;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] rd;
      bit sawReady;
      repeat (3) @(posedge clk);
      #1 reset = 0;

      issue(1, 32'h10, 32'h12345678, 2'b10, rd);
      issue(0, 32'h10, 32'h0, 2'b10, rd);
      chk("ld_0x10", rd, 32'h12345678);

      issue(1, 32'h20, 32'h0, 2'b10, rd);
      issue(1, 32'h22, 32'hAB, 2'b00, rd);
      issue(1, 32'h20, 32'hBEEF, 2'b01, rd);
      issue(0, 32'h20, 32'h0, 2'b10, rd);
      chk("ld_lanes", rd, 32'h00ABBEEF);

      issue(1, 32'd100, 32'd25, 2'b10, rd);
      chk("mbox_done", Done, 1);
      chk("mbox_pass", Pass, 1);
      issue(1, 32'd100, 32'd7, 2'b10, rd);
      chk("mbox2_done", Done, 1);
      chk("mbox2_pass", Pass, 1);
      issue(0, 32'd100, 32'h0, 2'b10, rd);
      chk("ld_mbox7", rd, 32'd7);

      issue(1, 32'h30, 32'h11223344, 2'b10, rd);
      MemReq = 1; MemWrite = 1; DataAddr = 32'h30;
      WriteData = 32'hFFFFFFFF; Size = 2'b10;
      @(posedge clk); #1;
      MemReq = 0;
      @(negedge clk); #2;
      chk("pre_rst_busy", Busy, 1);
      reset = 1;
      #1;
      chk("abort_busy", Busy, 0);
      chk("abort_ready", MemReady, 0);
      chk("abort_done", Done, 0);
      @(posedge clk); #1;
      reset = 0;
      sawReady = 0;
      repeat (6) begin
         @(negedge clk);
         if (MemReady) sawReady = 1;
      end
      chk("abort_noready", sawReady, 0);
      @(posedge clk); #1;
      issue(0, 32'h30, 32'h0, 2'b10, rd);
      chk("ld_abort", rd, 32'h11223344);

      issue(1, 32'd100, 32'd24, 2'b10, rd);
      chk("fail_done", Done, 1);
      chk("fail_pass", Pass, 0);
      issue(0, 32'd100, 32'h0, 2'b10, rd);
      chk("ld_mbox24", rd, 32'd24);

      issue(1, 32'h104, 32'h0BADCAFE, 2'b10, rd);
      issue(0, 32'h04, 32'h0, 2'b10, rd);
      chk("ld_wrap", rd, 32'h0BADCAFE);

      issue(1, 32'h40, 32'hCAFEF00D, 2'b10, rd);
      issue(1, 32'h41, 32'h11111111, 2'b10, rd);
`ifdef DMEM_MISALIGN_CHECK_EN
      chk("mis_flag", MisalignErr, 1);
      issue(0, 32'h40, 32'h0, 2'b10, rd);
      chk("ld_mis_keep", rd, 32'hCAFEF00D);
      issue(0, 32'h42, 32'h0, 2'b10, rd);
      chk("ld_mis_zero", rd, 32'h0);
`else
      chk("mis_tied", MisalignErr, 0);
      issue(0, 32'h40, 32'h0, 2'b10, rd);
      chk("ld_forced", rd, 32'h11111111);
      issue(1, 32'h23, 32'h5566, 2'b01, rd);
      issue(0, 32'h20, 32'h0, 2'b10, rd);
      chk("ld_half_al", rd, 32'h5566BEEF);
`endif

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
